// File: rtl/jtag_master.sv
// Host-side JTAG driver: runs DR/IR/reset scans on a TAP over a valid/ready command port.
// Optional build macro JTAG_MASTER_TRST_EN adds an active-low TRSTn output.
module jtag_master #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0]     cmd_len,
    input  logic [MAX_LEN-1:0]               cmd_data,
    output logic                             rsp_valid,
    output logic [MAX_LEN-1:0]               rsp_data,
    output logic                             TCK,
    output logic                             TMS,
    output logic                             TDI,
`ifdef JTAG_MASTER_TRST_EN
    output logic                             TRSTn,
`endif
    input  logic                             TDO
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = (LW > 3) ? LW : 3;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] LEN_MAX  = PW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_AUTO_RST,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic               half;
    logic [PW-1:0]      per;
    logic               op_ir, op_rst;
    logic [PW-1:0]      len_q, len_in, n_per;
    logic [MAX_LEN-1:0] data_q, cap_q;
    logic [PW:0]        shamt;
    logic               accept, per_end, seq_end, active;
    logic               tck_d, tms_d, tdi_d, rsp_valid_d, ready_d;

    assign accept  = cmd_valid & cmd_ready & (state == S_IDLE);
    assign per_end = half & (cnt == CNT_LAST);
    assign seq_end = per_end & (per == n_per - PW'(1));
    assign shamt   = (PW+1)'(MAX_LEN) - {1'b0, len_q};

    always_comb begin
        len_in = PW'(cmd_len);
        if (len_in > LEN_MAX)
            len_in = LEN_MAX;
    end

    always_comb begin
        n_per = '0;
        case (state)
            S_AUTO_RST: n_per = PW'(6);
            S_PRE:      n_per = op_rst ? PW'(6) : (op_ir ? PW'(4) : PW'(3));
            S_SHIFT:    n_per = len_q;
            S_POST:     n_per = PW'(2);
            default:    n_per = '0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_AUTO_RST;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_AUTO_RST: if (seq_end) state_nxt = S_IDLE;
            S_IDLE:     if (accept)
                            state_nxt = (!cmd_op[1] && len_in == '0) ? S_DONE : S_PRE;
            S_PRE:      if (seq_end) state_nxt = op_rst ? S_DONE : S_SHIFT;
            S_SHIFT:    if (seq_end) state_nxt = S_POST;
            S_POST:     if (seq_end) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_AUTO_RST;
        endcase
    end

    // Phase/period counters restart whenever the FSM changes state
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            half   <= 1'b0;
            per    <= '0;
            op_ir  <= 1'b0;
            op_rst <= 1'b0;
            len_q  <= '0;
            data_q <= '0;
            cap_q  <= '0;
        end else begin
            if (state_nxt != state) begin
                cnt  <= '0;
                half <= 1'b0;
                per  <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                half <= ~half;
                if (half)
                    per <= per + PW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (accept) begin
                op_ir  <= (cmd_op == 2'd1);
                op_rst <= cmd_op[1];
                len_q  <= len_in;
                data_q <= cmd_data;
                cap_q  <= '0;
            end

            // TDO enters at the top; after len shifts the first bit sits at MAX_LEN-len
            if (state == S_SHIFT) begin
                if (half && cnt == '0)
                    cap_q <= {TDO, cap_q[MAX_LEN-1:1]};
                if (per_end)
                    data_q <= data_q >> 1;
            end
        end
    end

    // Output logic
    always_comb begin
        active      = (state == S_AUTO_RST) || (state == S_PRE) ||
                      (state == S_SHIFT) || (state == S_POST);
        tck_d       = active & half;
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        rsp_valid_d = (state == S_DONE);
        ready_d     = (state == S_IDLE) && !accept;
        case (state)
            S_AUTO_RST: tms_d = (per < PW'(5));
            S_PRE:      tms_d = op_rst ? (per < PW'(5)) : (op_ir ? (per < PW'(2)) : (per == '0));
            S_SHIFT: begin
                tms_d = (per == len_q - PW'(1));
                tdi_d = data_q[0];
            end
            S_POST:     tms_d = (per == '0);
            default:    tms_d = 1'b0;
        endcase
    end

    // Pins are registered, so each sequence appears one cycle after its counters start
    always_ff @(posedge CLK) begin
        if (RST) begin
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            TCK       <= tck_d;
            TMS       <= tms_d;
            TDI       <= tdi_d;
            cmd_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            if (state == S_DONE)
                rsp_data <= op_rst ? '0 : (cap_q >> shamt);
        end
    end

`ifdef JTAG_MASTER_TRST_EN
    logic trstn_d;

    assign trstn_d = !(((state == S_AUTO_RST) || (state == S_PRE && op_rst)) && (per < PW'(5)));

    always_ff @(posedge CLK) begin
        if (RST)
            TRSTn <= 1'b0;
        else
            TRSTn <= trstn_d;
    end
`endif

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: drives a behavioural TAP target and scoreboards rsp_data.
// Honours JTAG_MASTER_TRST_EN when the design is built with it.
module tb_jtag_master;

    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam logic [31:0] IDCODE = 32'hF00ED093;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [LW-1:0]     cmd_len = '0;
    logic [31:0]       cmd_data = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              TCK, TMS, TDI;
    logic              TDO = 1'b0;
    logic              tap_trstn;

`ifdef JTAG_MASTER_TRST_EN
    logic TRSTn;
    assign tap_trstn = TRSTn;
`else
    assign tap_trstn = 1'b1;
`endif

    jtag_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
`ifdef JTAG_MASTER_TRST_EN
        .TRSTn     (TRSTn),
`endif
        .TDO       (TDO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Behavioural TAP target: 4-bit IR (IDCODE=1, BYPASS=F), 32-bit IDCODE DR
    typedef enum int {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t        tap = EX2_DR;
    logic [31:0] dr_sr = '0;
    logic        byp = 1'b0;
    logic [3:0]  ir = 4'h1;
    logic [3:0]  ir_sr = '0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PA_DR;
            PA_DR:   return m ? EX2_DR : PA_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PA_IR;
            PA_IR:   return m ? EX2_IR : PA_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge TCK or negedge tap_trstn) begin
        if (!tap_trstn) begin
            tap <= TLR;
            ir  <= 4'h1;
        end else begin
            case (tap)
                TLR:    ir <= 4'h1;
                CAP_DR: begin dr_sr <= IDCODE; byp <= 1'b0; end
                SH_DR:  begin dr_sr <= {TDI, dr_sr[31:1]}; byp <= TDI; end
                CAP_IR: ir_sr <= 4'b0101;
                SH_IR:  ir_sr <= {TDI, ir_sr[3:1]};
                UPD_IR: ir <= ir_sr;
                default: ;
            endcase
            tap <= tap_next(tap, TMS);
        end
    end

    always @(negedge TCK) begin
        if (tap == SH_DR)
            TDO <= (ir == 4'hF) ? byp : dr_sr[0];
        else if (tap == SH_IR)
            TDO <= ir_sr[0];
    end

    int          tck_cnt = 0;
    logic [31:0] tms_hist = '0;
    always @(posedge TCK) begin
        tck_cnt++;
        tms_hist = {tms_hist[30:0], TMS};
    end

    int trst_low = 0;
`ifdef JTAG_MASTER_TRST_EN
    always @(negedge CLK) if (TRSTn === 1'b0) trst_low++;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          rsp_seen = 0;
    int          rsp_cyc = 0;
    int          last_c0 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rsp_valid pulse consumes one expected response
    always @(negedge CLK) begin
        if (rsp_valid === 1'b1) begin
            rsp_seen++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: actual rsp_data=0x%0h required no response", rsp_data);
            end else begin
                check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_ready(input int budget);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < budget) begin
            @(negedge CLK);
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: actual cmd_ready=%b required 1 within %0d cycles", cmd_ready, budget);
        end
    endtask

    task automatic do_cmd(input string name, input logic [1:0] op, input int len,
                          input logic [31:0] data, input logic [31:0] exp, input int exp_per,
                          input logic [31:0] exp_tms, input bit chk_tms);
        int t0, r0;
        wait_ready(400);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LW'(len);
        cmd_data  = data;
        exp_q.push_back(exp);
        last_c0 = cyc;
        t0 = tck_cnt;
        r0 = rsp_seen;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = '1;
        cmd_data  = '1;
        check({name, "_ready_drop"}, 64'(cmd_ready), 64'd0);
        wait_ready(400);
        check({name, "_periods"}, 64'(tck_cnt - t0), 64'(exp_per));
        check({name, "_rsp_count"}, 64'(rsp_seen - r0), 64'd1);
        check({name, "_tap_rti"}, 64'(tap), 64'(RTI));
        if (chk_tms)
            check({name, "_tms"}, 64'(tms_hist & ((32'h1 << exp_per) - 32'h1)), 64'(exp_tms));
    endtask

    initial begin
        int c0, t0, r0, l0;

        @(negedge CLK);
        check("rst_tck", 64'(TCK), 64'd0);
        check("rst_tms", 64'(TMS), 64'd1);
        check("rst_tdi", 64'(TDI), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
`ifdef JTAG_MASTER_TRST_EN
        check("rst_trstn", 64'(TRSTn), 64'd0);
`endif
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        c0 = cyc;
        t0 = tck_cnt;
        wait_ready(100);
        check("autorst_ready_cycle", 64'(cyc - c0), 64'd25);
        check("autorst_periods", 64'(tck_cnt - t0), 64'd6);
        check("autorst_tms", 64'(tms_hist[5:0]), 64'(6'b111110));
        check("autorst_tap_rti", 64'(tap), 64'(RTI));

        do_cmd("dr32", 2'd0, 32, 32'h0000007F, IDCODE, 37, '0, 1'b0);
        do_cmd("dr8", 2'd0, 8, 32'h000000A5, 32'h00000093, 13, 32'b1000000000110, 1'b1);
        do_cmd("dr0", 2'd0, 0, 32'h12345678, 32'h0, 0, '0, 1'b0);
        check("dr0_latency", 64'(rsp_cyc - last_c0), 64'd2);
        do_cmd("dr40", 2'd0, 40, 32'h0, IDCODE, 37, '0, 1'b0);
        do_cmd("ir_bypass", 2'd1, 4, 32'hF, 32'h5, 10, 32'b1100000110, 1'b1);
        do_cmd("dr8_bypass", 2'd0, 8, 32'h000000A5, 32'h0000004A, 13, '0, 1'b0);

        l0 = trst_low;
        do_cmd("reset_op", 2'd2, 0, 32'h0, 32'h0, 6, 32'b111110, 1'b1);
`ifdef JTAG_MASTER_TRST_EN
        check("reset_op_trst_low", 64'(trst_low - l0), 64'd20);
`endif
        do_cmd("dr8_after_reset", 2'd0, 8, 32'h0, 32'h00000093, 13, '0, 1'b0);
        do_cmd("ir_bypass2", 2'd1, 4, 32'hF, 32'h5, 10, '0, 1'b0);
        do_cmd("op3_reset", 2'd3, 8, 32'hFF, 32'h0, 6, 32'b111110, 1'b1);
        do_cmd("dr8_after_op3", 2'd0, 8, 32'h0, 32'h00000093, 13, '0, 1'b0);

        // Abort a DR scan after 3 entry periods plus 10 shift periods
        wait_ready(400);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_len   = LW'(32);
        cmd_data  = 32'hDEADBEEF;
        t0 = tck_cnt;
        @(negedge CLK);
        cmd_valid = 1'b0;
        for (int i = 0; i < 400 && tck_cnt < t0 + 13; i++) @(negedge CLK);
        check("abort_reached_shift", 64'(tck_cnt - t0), 64'd13);
        r0 = rsp_seen;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_tck", 64'(TCK), 64'd0);
        check("abort_tms", 64'(TMS), 64'd1);
        check("abort_ready", 64'(cmd_ready), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        RST = 1'b0;
        wait_ready(100);
        check("abort_no_rsp", 64'(rsp_seen - r0), 64'd0);
        check("abort_tap_rti", 64'(tap), 64'(RTI));
        do_cmd("dr32_after_abort", 2'd0, 32, 32'h0000007F, IDCODE, 37, '0, 1'b0);

        repeat (4) @(negedge CLK);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running required finish before 500000 time units");
        $fatal(1);
    end

endmodule
